err_conv_monitor: RTL and testbench
===================================

ERR_CONV_MONITOR -- requirements
Module: err_conv_monitor

Interface
- REQ-001: Parameter ERR_WIDTH, default 14: width of the two's-complement error sample from the LMS stage.
- REQ-002: Parameter WIN_LOG2, default 4: log2 of the averaging window length (16 samples).
- REQ-003: Parameter CONV_THRESH, default 64: average-magnitude threshold for convergence; unsigned.
- REQ-004: Parameter DIV_THRESH, default 4096: average-magnitude threshold for divergence; unsigned, greater than CONV_THRESH.
- REQ-005: Parameter HOLD_COUNT, default 3: consecutive windows required to enter or leave CONV.
- REQ-006: One clock; reset is asynchronous and active-high.
- REQ-007: clk  input  1  system clock; all state on rising edge.
- REQ-008: rst  input  1  asynchronous, active-high reset.
- REQ-009: enable  input  1  monitor run control.
- REQ-010: err_valid  input  1  err sample strobe.
- REQ-011: err  input  ERR_WIDTH  signed e(n) from the LMS canceller.
- REQ-012: mag_avg  output  ERR_WIDTH  mean |err| of the last completed window; unsigned.
- REQ-013: avg_valid  output  1  one-cycle pulse when mag_avg updates.
- REQ-014: state  output  2  monitor state: IDLE=0, ADAPT=1, CONV=2, DIVERGE=3.
- REQ-015: converged  output  1  high when state==CONV.
- REQ-016: diverged  output  1  high when state==DIVERGE.

Function
- REQ-017: A sample is accepted on a rising edge where enable=1 and err_valid=1; no other sample affects the block.
- REQ-018: The magnitude of each accepted sample is |err|; the most negative code saturates to 2^(ERR_WIDTH-1)-1.
- REQ-019: The accumulator is ERR_WIDTH+WIN_LOG2 bits wide and never overflows.
- REQ-020: Averaging is block-based, not sliding: a sample counter wraps from 2^WIN_LOG2-1 to 0.
- REQ-021: On the edge that accepts the last sample of a window:
  - mag_avg loads (accumulator + magnitude) >> WIN_LOG2, truncated;
  - avg_valid is 1 for exactly the following cycle;
  - the accumulator restarts at 0;
  - state is updated on the same edge.
- REQ-022: The state transition is evaluated only on a window-complete edge, using the new average A:
  - from ADAPT or CONV, A >= DIV_THRESH: go to DIVERGE immediately.
  - in ADAPT: count consecutive windows with A < CONV_THRESH (any other A clears the count); on reaching HOLD_COUNT, go to CONV and clear the count.
  - in CONV: count consecutive windows with A >= CONV_THRESH; on reaching HOLD_COUNT, go to ADAPT and clear the count.
- REQ-023: DIVERGE is sticky; only enable=0 or reset leaves it.
- REQ-024: From IDLE, enable=1 moves the block to ADAPT on the next edge; a sample accepted on that same edge counts as window sample 0.
- REQ-025: On any edge with enable=0, the block goes to IDLE and clears the accumulator, sample counter and hold counter.
  - mag_avg holds its value.
  - avg_valid is 0.
  - Any err_valid on that edge is discarded.
- REQ-026: A partial window abandoned by enable=0 produces no avg_valid.
- REQ-027: Gaps in err_valid stall the window; the window completes only after 2^WIN_LOG2 accepted samples.

Reset
- REQ-028: While rst=1, all outputs and internal registers are held at reset values, independent of clk: mag_avg=0, avg_valid=0, state=IDLE, converged=0, diverged=0, all counters and the accumulator 0.
- REQ-029: Reset asserted mid-window discards the partial window.
- REQ-030: The first edge after rst falls behaves as the IDLE case of REQ-024/REQ-025.

Verification
- REQ-031: Reset with enable=1 and err_valid=1 toggling -> all outputs 0 and state=0 throughout; after release, state=1 one edge later.
- REQ-032: Sixteen consecutive samples of err=+100 -> avg_valid high exactly in the cycle after the 16th sample, mag_avg=100, state stays 1.
- REQ-033: Three windows alternating +40/-40 -> mag_avg=40 each window; converged=1 only after the 3rd avg_valid. Then two windows of 200 -> still CONV; a third window of 200 -> state=1.
- REQ-034: One window of err=-8192 (min code) -> mag_avg=8191, state=3, diverged=1. Subsequent windows of err=0 -> stays 3. enable=0 for one edge -> state=0.
- REQ-035: err_valid every 3rd cycle, 16 samples of +50 -> a single avg_valid after the 16th accepted sample, mag_avg=50. Second run: enable dropped after 10 samples, then 16 samples of +8 -> no avg_valid for the partial window, next mag_avg=8.
- REQ-036: rst pulsed asynchronously between clock edges mid-window in state 2 -> outputs clear immediately; the next full window is averaged from fresh samples only.

Source files
------------

// File: rtl/err_conv_monitor.sv
// LMS error convergence monitor: block-averages |err| over 2^WIN_LOG2 accepted samples
// and classifies the canceller as adapting, converged or diverged.
module err_conv_monitor #(
  parameter int          ERR_WIDTH   = 14,
  parameter int          WIN_LOG2    = 4,
  parameter int unsigned CONV_THRESH = 64,
  parameter int unsigned DIV_THRESH  = 4096,
  parameter int unsigned HOLD_COUNT  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        err_valid,
  input  logic signed [ERR_WIDTH-1:0] err,
  output logic        [ERR_WIDTH-1:0] mag_avg,
  output logic                        avg_valid,
  output logic        [1:0]           state,
  output logic                        converged,
  output logic                        diverged
);

  localparam int ACC_W  = ERR_WIDTH + WIN_LOG2;
  localparam int HOLD_W = $clog2(HOLD_COUNT + 1);
  localparam logic [ERR_WIDTH-1:0] MIN_CODE = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic [ERR_WIDTH-1:0] MAX_POS  = {1'b0, {(ERR_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADAPT   = 2'd1,
    CONV    = 2'd2,
    DIVERGE = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [ACC_W-1:0]     acc_reg, acc_next;
  logic [WIN_LOG2-1:0]  cnt_reg, cnt_next;
  logic [HOLD_W-1:0]    hold_reg, hold_next;
  logic [ERR_WIDTH-1:0] mag_reg, mag_next;
  logic                 valid_reg, valid_next;

  logic [ERR_WIDTH-1:0] err_u;
  logic [ERR_WIDTH-1:0] mag;
  logic [ACC_W-1:0]     sum;
  logic [ERR_WIDTH-1:0] avg_new;
  logic [HOLD_W-1:0]    hold_inc;
  logic                 accept;
  logic                 win_done;
  logic                 above_div;
  logic                 below_conv;
  logic                 hold_reached;

  assign err_u = err;

  // The most negative code has no positive twin, so it saturates.
  always_comb begin
    mag = err_u;
    if (err_u == MIN_CODE) begin
      mag = MAX_POS;
    end else if (err_u[ERR_WIDTH-1]) begin
      mag = ~err_u + 1'b1;
    end
  end

  assign accept       = enable & err_valid;
  assign win_done     = accept && (cnt_reg == {WIN_LOG2{1'b1}});
  assign sum          = acc_reg + {{WIN_LOG2{1'b0}}, mag};
  assign avg_new      = sum[ACC_W-1:WIN_LOG2];
  assign hold_inc     = hold_reg + 1'b1;
  assign above_div    = 32'(avg_new) >= DIV_THRESH;
  assign below_conv   = 32'(avg_new) < CONV_THRESH;
  assign hold_reached = 32'(hold_inc) >= HOLD_COUNT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      hold_reg  <= '0;
      mag_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= hold_next;
      mag_reg   <= mag_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    mag_next   = mag_reg;
    valid_next = 1'b0;

    if (!enable) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
      hold_next  = '0;
    end else begin
      if (accept) begin
        cnt_next = cnt_reg + 1'b1;
        if (win_done) begin
          acc_next   = '0;
          mag_next   = avg_new;
          valid_next = 1'b1;
        end else begin
          acc_next = sum;
        end
      end

      // Classification only moves on window-complete edges; IDLE leaves on any enabled edge.
      unique case (state_reg)
        IDLE: state_next = ADAPT;
        ADAPT: begin
          if (win_done) begin
            if (above_div) begin
              state_next = DIVERGE;
              hold_next  = '0;
            end else if (below_conv) begin
              if (hold_reached) begin
                state_next = CONV;
                hold_next  = '0;
              end else begin
                hold_next = hold_inc;
              end
            end else begin
              hold_next = '0;
            end
          end
        end
        CONV: begin
          if (win_done) begin
            if (above_div) begin
              state_next = DIVERGE;
              hold_next  = '0;
            end else if (!below_conv) begin
              if (hold_reached) begin
                state_next = ADAPT;
                hold_next  = '0;
              end else begin
                hold_next = hold_inc;
              end
            end else begin
              hold_next = '0;
            end
          end
        end
        DIVERGE: state_next = DIVERGE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign mag_avg   = mag_reg;
  assign avg_valid = valid_reg;
  assign state     = state_reg;
  assign converged = (state_reg == CONV);
  assign diverged  = (state_reg == DIVERGE);

endmodule

// File: tb/tb_err_conv_monitor.sv
// Directed table-driven bench for err_conv_monitor with hand-computed expectations.
module tb_err_conv_monitor;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               err_valid;
  logic signed [13:0] err;
  logic [13:0]        mag_avg;
  logic               avg_valid;
  logic [1:0]         state;
  logic               converged;
  logic               diverged;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  err_conv_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .err_valid (err_valid),
    .err       (err),
    .mag_avg   (mag_avg),
    .avg_valid (avg_valid),
    .state     (state),
    .converged (converged),
    .diverged  (diverged)
  );

  // Each row drives n accepted-sample edges (optionally alternating sign, with idle gaps)
  // and states the expected avg_valid on the last sample edge plus final mag_avg/state.
  typedef struct {
    logic               en;
    logic               vld;
    logic signed [13:0] err;
    bit                 alt;
    int                 n;
    int                 gap;
    logic               exp_valid;
    int                 exp_mag;
    int                 exp_state;
  } row_t;

  row_t rows[$];

  task automatic add_row(input logic en, input logic vld, input int e, input bit alt,
                         input int n, input int gap, input logic ev, input int em,
                         input int es);
    row_t r;
    r.en = en; r.vld = vld; r.err = 14'(e); r.alt = alt; r.n = n; r.gap = gap;
    r.exp_valid = ev; r.exp_mag = em; r.exp_state = es;
    rows.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input int em, input int ev, input int es);
    chk({tag, " mag_avg"}, int'(mag_avg), em);
    chk({tag, " avg_valid"}, int'(avg_valid), ev);
    chk({tag, " state"}, int'(state), es);
    chk({tag, " converged"}, int'(converged), int'(es == 2));
    chk({tag, " diverged"}, int'(diverged), int'(es == 3));
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      row_t row;
      int pulses;
      row = rows[r];
      pulses = 0;
      for (int s = 0; s < row.n; s++) begin
        enable    = row.en;
        err_valid = row.vld;
        err       = (row.alt && (s % 2 == 1)) ? -row.err : row.err;
        step();
        pulses += int'(avg_valid);
        chk($sformatf("row%0d s%0d avg_valid", r, s), int'(avg_valid),
            int'((s == row.n - 1) && row.exp_valid));
        for (int g = 0; g < row.gap; g++) begin
          err_valid = 1'b0;
          step();
          pulses += int'(avg_valid);
          chk($sformatf("row%0d s%0d gap avg_valid", r, s), int'(avg_valid), 0);
        end
      end
      chk($sformatf("row%0d mag_avg", r), int'(mag_avg), row.exp_mag);
      chk($sformatf("row%0d state", r), int'(state), row.exp_state);
      chk($sformatf("row%0d converged", r), int'(converged), int'(row.exp_state == 2));
      chk($sformatf("row%0d diverged", r), int'(diverged), int'(row.exp_state == 3));
      $display("row %0d: en=%0d vld=%0d err=%0d n=%0d gap=%0d -> mag_avg=%0d state=%0d pulses=%0d",
               r, row.en, row.vld, row.err, row.n, row.gap, mag_avg, state, pulses);
    end
  endtask

  initial begin
    //       en vld  err   alt n  gap ev  mag   st
    add_row(1, 0,    0,   0, 1,  0, 0,    0, 1);  // 0  release -> ADAPT
    add_row(1, 1,  100,   0, 16, 0, 1,  100, 1);  // 1
    add_row(1, 1,   40,   1, 16, 0, 1,   40, 1);  // 2  hold 1
    add_row(1, 1,   40,   1, 16, 0, 1,   40, 1);  // 3  hold 2
    add_row(1, 1,   40,   1, 16, 0, 1,   40, 2);  // 4  CONV
    add_row(1, 1,  200,   0, 16, 0, 1,  200, 2);  // 5
    add_row(1, 1,  200,   0, 16, 0, 1,  200, 2);  // 6
    add_row(1, 1,  200,   0, 16, 0, 1,  200, 1);  // 7  back to ADAPT
    add_row(1, 1, -8192,  0, 16, 0, 1, 8191, 3);  // 8  min code saturates, DIVERGE
    add_row(1, 1,    0,   0, 16, 0, 1,    0, 3);  // 9  sticky
    add_row(0, 1,  500,   0, 1,  0, 0,    0, 0);  // 10 enable low -> IDLE
    add_row(1, 0,    0,   0, 1,  0, 0,    0, 1);  // 11
    add_row(1, 1,   50,   0, 16, 2, 1,   50, 1);  // 12 sparse strobes
    add_row(1, 1,   50,   0, 10, 0, 0,   50, 1);  // 13 partial window
    add_row(0, 1,   50,   0, 1,  0, 0,   50, 0);  // 14 abandon, mag held
    add_row(1, 0,    0,   0, 1,  0, 0,   50, 1);  // 15
    add_row(1, 1,    8,   0, 16, 0, 1,    8, 1);  // 16 fresh window only
    add_row(0, 0,    0,   0, 1,  0, 0,    8, 0);  // 17 clear hold count
    add_row(1, 0,    0,   0, 1,  0, 0,    8, 1);  // 18
    add_row(1, 1, 4000,   0, 7,  0, 0,   40, 2);  // 19 partial window in CONV
    add_row(1, 0,    0,   0, 1,  0, 0,    0, 1);  // 20 first edge after reset
    add_row(1, 1,   10,   0, 16, 0, 1,   10, 1);  // 21 averaged from fresh samples

    rst = 1'b1; enable = 1'b0; err_valid = 1'b0; err = '0;
    #1;
    chk_outputs("reset t0", 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      enable    = (i % 2 == 0);
      err_valid = (i % 3 != 2);
      err       = 14'(-8192 + i * 1000);
      step();
      chk_outputs($sformatf("reset edge%0d", i), 0, 0, 0);
      $display("reset edge %0d: en=%0d vld=%0d -> mag_avg=%0d state=%0d", i, enable,
               err_valid, mag_avg, state);
    end
    rst = 1'b0;

    run_rows(0, 18);
    run_rows(2, 4);
    run_rows(19, 19);

    // Asynchronous reset between edges while in CONV with a partial window pending.
    #2;
    rst = 1'b1;
    #1;
    chk_outputs("async rst", 0, 0, 0);
    $display("async rst mid-cycle: mag_avg=%0d state=%0d", mag_avg, state);
    enable = 1'b1; err_valid = 1'b1; err = 14'(4000);
    step();
    chk_outputs("async rst held", 0, 0, 0);
    rst = 1'b0;

    run_rows(20, 21);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
